// File: rtl/price_bcd_converter.sv
// Binary price (cents) to BCD digit converter using an iterative shift-add-3 engine.
// One input bit per clock, plus a finish cycle that publishes the digits and the blank/invalid flags.
module price_bcd_converter #(
   parameter int IN_W = 12,
   parameter int DIGITS = 4,
   parameter logic [IN_W-1:0] INVALID_CODE = {IN_W{1'b1}}
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [IN_W-1:0]       PRICE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  BLANK_THOU,
   output logic                  INVALID
);

   localparam int CW = $clog2(IN_W + 1);
   localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t              state, next_state;
   logic [IN_W-1:0]     shift_reg;
   logic [4*DIGITS-1:0] bcd_acc;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [CW-1:0]       cnt;
   logic                inv_flag;

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (START) next_state = SHIFT;
         SHIFT:   if (cnt == LAST) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Nibbles of 5 or more become >= 10 after the shift, so pre-add 3 to carry into the next digit.
   always_comb begin
      bcd_adj = bcd_acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_acc[4*d +: 4] >= 4'd5)
            bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         shift_reg  <= '0;
         bcd_acc    <= '0;
         cnt        <= '0;
         inv_flag   <= 1'b0;
         DONE       <= 1'b0;
         BCD        <= '0;
         BLANK_THOU <= 1'b0;
         INVALID    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  shift_reg <= PRICE;
                  bcd_acc   <= '0;
                  cnt       <= '0;
                  inv_flag  <= (PRICE == INVALID_CODE);
               end
            end
            SHIFT: begin
               {bcd_acc, shift_reg} <= {bcd_adj, shift_reg} << 1;
               cnt <= cnt + 1'b1;
            end
            FINISH: begin
               DONE <= 1'b1;
               if (inv_flag) begin
                  // All-ones nibbles are the display's blank code.
                  BCD        <= '1;
                  BLANK_THOU <= 1'b0;
                  INVALID    <= 1'b1;
               end else begin
                  BCD        <= bcd_acc;
                  BLANK_THOU <= (bcd_acc[4*DIGITS-1 -: 4] == 4'd0);
                  INVALID    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign BUSY = (state != IDLE);

endmodule
